// File: rtl/spdif_frame_assemble_if.sv
// Sample-pair handshake between the upstream PCM source and the S/PDIF framer.
interface spdif_frame_assemble_if #(
  parameter int unsigned SAMPLE_WIDTH = 24
);
  logic [SAMPLE_WIDTH-1:0] sample_l;
  logic [SAMPLE_WIDTH-1:0] sample_r;
  logic                    sample_valid;
  logic                    sample_ready;

  // A pair transfers on a rising clk edge where sample_valid && sample_ready;
  // the source holds data stable while valid is high and not yet accepted.
  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/spdif_frame_assemble.sv
// S/PDIF transmit framer: one clk per BMC half-cell, 128 half-cells per stereo
// frame, 192-frame blocks, one holding register ahead of the frame registers.
module spdif_frame_assemble #(
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter logic [31:0] CS_WORD      = 32'h0200_0004
) (
  input  logic                   clk,
  input  logic                   rst,
  spdif_frame_assemble_if.slave  smp,
  output logic                   spdif_out_o,
  output logic                   frame_start_o,
  output logic                   underrun_o
);

  localparam int unsigned PAD   = 24 - SAMPLE_WIDTH;
  localparam logic [7:0]  PRE_B = 8'b1110_1000;
  localparam logic [7:0]  PRE_M = 8'b1110_0010;
  localparam logic [7:0]  PRE_W = 8'b1110_0100;

  logic [6:0]              hc_q, hc_d;
  logic [7:0]              frame_idx_q, frame_idx_d;
  logic                    hold_full_q, hold_full_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_WIDTH-1:0] hold_r_q, hold_r_d;
  logic [23:0]             frame_l_q, frame_l_d;
  logic [23:0]             frame_r_q, frame_r_d;
  logic                    spdif_q, spdif_d;
  logic                    frame_start_q, frame_start_d;
  logic                    underrun_q, underrun_d;

  logic       load_edge;
  logic       accept;
  logic [4:0] slot;
  logic [4:0] audio_idx;
  logic [23:0] word;
  logic       cs_bit;
  logic       parity;
  logic       data_bit;
  logic [7:0] pre;
  logic [7:0] pre_trans;
  logic       toggle;

  assign load_edge        = (hc_q == 7'd127);
  assign accept           = smp.sample_valid && !hold_full_q;
  assign smp.sample_ready = !hold_full_q;
  assign spdif_out_o      = spdif_q;
  assign frame_start_o    = frame_start_q;
  assign underrun_o       = underrun_q;

  // Counters, holding register and frame load.
  always_comb begin
    hc_d        = hc_q + 7'd1;
    frame_idx_d = frame_idx_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    frame_l_d   = frame_l_q;
    frame_r_d   = frame_r_q;
    if (load_edge) begin
      frame_idx_d = (frame_idx_q == 8'd191) ? 8'd0 : frame_idx_q + 8'd1;
      frame_l_d   = hold_full_q ? (24'(hold_l_q) << PAD) : 24'h0;
      frame_r_d   = hold_full_q ? (24'(hold_r_q) << PAD) : 24'h0;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = smp.sample_l;
      hold_r_d    = smp.sample_r;
    end
  end

  // Line encoder: every half-cell is expressed as "toggle or hold" relative
  // to the current line level, which makes preamble inversion automatic.
  always_comb begin
    slot      = hc_q[5:1];
    audio_idx = slot - 5'd4;
    word      = hc_q[6] ? frame_r_q : frame_l_q;
    cs_bit    = (frame_idx_q < 8'd32) ? CS_WORD[frame_idx_q[4:0]] : 1'b0;
    parity    = (^word) ^ cs_bit;
    case (slot)
      5'd28, 5'd29: data_bit = 1'b0;
      5'd30:        data_bit = cs_bit;
      5'd31:        data_bit = parity;
      default:      data_bit = word[audio_idx];
    endcase
    if (hc_q[6]) begin
      pre = PRE_W;
    end else if (frame_idx_q == 8'd0) begin
      pre = PRE_B;
    end else begin
      pre = PRE_M;
    end
    pre_trans = pre ^ {1'b0, pre[7:1]};
    if (slot < 5'd4) begin
      toggle = pre_trans[3'd7 - hc_q[2:0]];
    end else begin
      toggle = !hc_q[0] || data_bit;
    end
    spdif_d       = spdif_q ^ toggle;
    frame_start_d = (hc_q == 7'd0);
    underrun_d    = load_edge && !hold_full_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q          <= '0;
      frame_idx_q   <= '0;
      hold_full_q   <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      frame_l_q     <= '0;
      frame_r_q     <= '0;
      spdif_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      frame_idx_q   <= frame_idx_d;
      hold_full_q   <= hold_full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      frame_l_q     <= frame_l_d;
      frame_r_q     <= frame_r_d;
      spdif_q       <= spdif_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

endmodule

// File: tb/tb_spdif_frame_assemble.sv
// Bench for spdif_frame_assemble: frame-level scoreboard of the line output
// against a reference encoder, plus decoded-field checks on captured frames.
module tb_spdif_frame_assemble;

  localparam int          SW = 24;
  localparam logic [31:0] CS = 32'h0200_0004;
  localparam logic [7:0]  PB = 8'b1110_1000;
  localparam logic [7:0]  PM = 8'b1110_0010;
  localparam logic [7:0]  PW = 8'b1110_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spdif_out, frame_start, underrun;

  spdif_frame_assemble_if #(.SAMPLE_WIDTH(SW)) smp ();

  spdif_frame_assemble #(.SAMPLE_WIDTH(SW), .CS_WORD(CS)) dut (
    .clk           (clk),
    .rst           (rst),
    .smp           (smp),
    .spdif_out_o   (spdif_out),
    .frame_start_o (frame_start),
    .underrun_o    (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        c;
    logic        pl;
    logic        pr;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          cnt;
  int          m_fidx;
  logic        m_level, m_full;
  logic [23:0] m_l, m_r;
  logic [127:0] exp_q[$];
  logic         und_q[$];
  logic [127:0] line_buf, fs_buf, und_buf;
  logic [127:0] cap [0:199];
  int          rdy_bad;
  logic        acc_flag;
  int          acc_cyc;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference encoder: builds the 128 half-cells of one frame level by level.
  function automatic void enc_frame(input logic [23:0] l, input logic [23:0] r, input int fidx,
                                    input logic lvl_in, output logic [127:0] line, output logic lvl_out);
    logic        lvl;
    int          pos;
    int          ones;
    logic [7:0]  pre;
    logic [23:0] w;
    logic [27:0] bits;
    lvl  = lvl_in;
    pos  = 127;
    line = '0;
    for (int sub = 0; sub < 2; sub++) begin
      pre = (sub == 1) ? PW : ((fidx == 0) ? PB : PM);
      if (lvl) pre = ~pre;
      for (int i = 7; i >= 0; i--) begin
        line[pos] = pre[i];
        pos--;
      end
      lvl  = pre[0];
      w    = (sub == 1) ? r : l;
      bits = '0;
      for (int k = 0; k < 24; k++) bits[k] = w[k];
      if (fidx < 32) bits[26] = CS[fidx];
      ones = 0;
      for (int k = 0; k < 27; k++) if (bits[k]) ones++;
      bits[27] = ((ones % 2) == 1);
      for (int k = 0; k < 28; k++) begin
        lvl = ~lvl;
        line[pos] = lvl;
        pos--;
        if (bits[k]) lvl = ~lvl;
        line[pos] = lvl;
        pos--;
      end
    end
    lvl_out = lvl;
  endfunction

  function automatic logic slot_bit(input logic [127:0] ln, input int sub, input int s);
    int h;
    h = sub * 64 + 2 * s;
    return ln[127-h] ^ ln[126-h];
  endfunction

  function automatic logic [23:0] audio_of(input logic [127:0] ln, input int sub);
    logic [23:0] a;
    for (int k = 0; k < 24; k++) a[k] = slot_bit(ln, sub, 4 + k);
    return a;
  endfunction

  function automatic logic [7:0] pre_of(input int fn, input int sub);
    logic       prior;
    logic [7:0] raw;
    if (sub == 1) begin
      prior = cap[fn][64];
      raw   = cap[fn][63:56];
    end else begin
      prior = 1'b0;
      if (fn > 0) prior = cap[fn-1][0];
      raw = cap[fn][127:120];
    end
    return prior ? ~raw : raw;
  endfunction

  task automatic frame_done(input int fn);
    logic [127:0] e;
    logic         u;
    if (fn < 200) cap[fn] = line_buf;
    if (exp_q.size() == 0 || und_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_empty frame=%0d got=frame exp=no_frame", fn);
    end else begin
      e = exp_q.pop_front();
      u = und_q.pop_front();
      check($sformatf("line_f%0d", fn), line_buf, e);
      check($sformatf("underrun_f%0d", fn), und_buf, {127'b0, u});
    end
    check($sformatf("frame_start_f%0d", fn), fs_buf, {1'b1, 127'b0});
    check($sformatf("ready_f%0d", fn), 128'(rdy_bad), 128'd0);
    rdy_bad = 0;
  endtask

  // One clock: step the bench model for the current cycle, then sample #1 after the edge.
  task automatic tick();
    int           oidx;
    int           fn;
    logic [23:0]  ll, rr;
    logic [127:0] ln;
    logic         lv;
    logic         acc;
    if (!rst) begin
      if (smp.sample_ready !== !m_full) rdy_bad++;
      acc = smp.sample_valid && !m_full;
      if ((cnt % 128) == 127) begin
        ll = m_full ? m_l : 24'h0;
        rr = m_full ? m_r : 24'h0;
        und_q.push_back(!m_full);
        m_fidx = (m_fidx == 191) ? 0 : m_fidx + 1;
        enc_frame(ll, rr, m_fidx, m_level, ln, lv);
        exp_q.push_back(ln);
        m_level = lv;
        m_full  = 1'b0;
      end
      if (acc) begin
        m_full   = 1'b1;
        m_l      = smp.sample_l;
        m_r      = smp.sample_r;
        acc_flag = 1'b1;
        acc_cyc  = cnt;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      cnt = 0;
    end else begin
      cnt++;
      oidx = (cnt - 1) % 128;
      fn   = (cnt - 1) / 128;
      line_buf[127-oidx] = spdif_out;
      fs_buf[127-oidx]   = frame_start;
      und_buf[127-oidx]  = underrun;
      if (oidx == 127) frame_done(fn);
    end
  endtask

  task automatic do_reset();
    logic [127:0] ln;
    logic         lv;
    rst = 1'b1;
    smp.sample_valid = 1'b0;
    tick();
    check("rst_spdif_out", 128'(spdif_out), 128'd0);
    check("rst_sample_ready", 128'(smp.sample_ready), 128'd1);
    check("rst_frame_start", 128'(frame_start), 128'd0);
    check("rst_underrun", 128'(underrun), 128'd0);
    rst     = 1'b0;
    cnt     = 0;
    m_fidx  = 0;
    m_full  = 1'b0;
    rdy_bad = 0;
    exp_q.delete();
    und_q.delete();
    enc_frame(24'h0, 24'h0, 0, 1'b0, ln, lv);
    exp_q.push_back(ln);
    m_level = lv;
  endtask

  task automatic run_until(input int target);
    while (cnt < target) tick();
  endtask

  task automatic offer(input logic [23:0] l, input logic [23:0] r, output int ac);
    int n;
    smp.sample_l     = l;
    smp.sample_r     = r;
    smp.sample_valid = 1'b1;
    acc_flag = 1'b0;
    n = 0;
    while (!acc_flag && n < 400) begin
      tick();
      n++;
    end
    ac = acc_cyc;
    if (!acc_flag) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout got=no_accept exp=accept");
      ac = -1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[4];
    int           ac;
    int           bad;
    int           cs_fn[5];
    logic         cs_exp[5];
    logic [127:0] ln;
    logic [7:0]   want;

    vecs[0] = '{24'h000001, 24'h000000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{24'h000003, 24'hFFFFFF, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{24'h800000, 24'hABCDEF, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{24'h123456, 24'h000F00, 1'b0, 1'b1, 1'b0};
    cs_fn   = '{0, 1, 2, 25, 40};
    cs_exp  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    smp.sample_l     = '0;
    smp.sample_r     = '0;
    smp.sample_valid = 1'b0;
    cnt      = 0;
    rdy_bad  = 0;
    acc_flag = 1'b0;
    acc_cyc  = 0;

    // Table vectors, valid held high across consecutive pairs.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      offer(vecs[i].l, vecs[i].r, ac);
      check($sformatf("accept_cycle%0d", i), 128'(ac), 128'(i * 128));
    end
    smp.sample_valid = 1'b0;
    run_until(6 * 128);
    check("first_preamble_b", 128'(cap[0][127:120]), 128'(PB));
    for (int i = 0; i < 4; i++) begin
      ln = cap[i+1];
      check($sformatf("v%0d_audio_l", i), 128'(audio_of(ln, 0)), 128'(vecs[i].l));
      check($sformatf("v%0d_audio_r", i), 128'(audio_of(ln, 1)), 128'(vecs[i].r));
      check($sformatf("v%0d_vu", i),
            128'({slot_bit(ln, 0, 28), slot_bit(ln, 0, 29), slot_bit(ln, 1, 28), slot_bit(ln, 1, 29)}), 128'd0);
      check($sformatf("v%0d_c", i), 128'({slot_bit(ln, 0, 30), slot_bit(ln, 1, 30)}),
            128'({vecs[i].c, vecs[i].c}));
      check($sformatf("v%0d_p_l", i), 128'(slot_bit(ln, 0, 31)), 128'(vecs[i].pl));
      check($sformatf("v%0d_p_r", i), 128'(slot_bit(ln, 1, 31)), 128'(vecs[i].pr));
      check($sformatf("v%0d_pre_l", i), 128'(pre_of(i + 1, 0)), 128'(PM));
      check($sformatf("v%0d_pre_r", i), 128'(pre_of(i + 1, 1)), 128'(PW));
    end

    // Full block plus wrap with random audio.
    do_reset();
    for (int k = 0; k < 194; k++) begin
      offer(24'($urandom_range(0, 32'h00FF_FFFF)), 24'($urandom_range(0, 32'h00FF_FFFF)), ac);
    end
    smp.sample_valid = 1'b0;
    run_until(195 * 128);
    check("block_b_f0", 128'(pre_of(0, 0)), 128'(PB));
    check("block_b_f192", 128'(pre_of(192, 0)), 128'(PB));
    bad = 0;
    for (int fn = 0; fn < 195; fn++) begin
      want = ((fn % 192) == 0) ? PB : PM;
      if (pre_of(fn, 0) !== want) bad++;
      if (pre_of(fn, 1) !== PW) bad++;
    end
    check("block_preamble_errors", 128'(bad), 128'd0);
    for (int i = 0; i < 5; i++) begin
      ln = cap[cs_fn[i]];
      check($sformatf("cs_f%0d", cs_fn[i]), 128'({slot_bit(ln, 0, 30), slot_bit(ln, 1, 30)}),
            128'({cs_exp[i], cs_exp[i]}));
    end

    // Reset in the middle of a frame carrying audio, with a pair waiting in holding.
    do_reset();
    offer(24'hABCDEF, 24'h123456, ac);
    offer(24'h111111, 24'h222222, ac);
    check("pre_reset_accept", 128'(ac), 128'd128);
    smp.sample_valid = 1'b0;
    run_until(178);
    do_reset();
    run_until(3 * 128);
    check("restart_preamble_b", 128'(cap[0][127:120]), 128'(PB));
    check("restart_silent_l", 128'(audio_of(cap[0], 0)), 128'd0);
    check("discarded_holding", 128'({audio_of(cap[1], 0), audio_of(cap[1], 1)}), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
